gam_edge_age_engine: RTL and testbench

Parametrised connection-age manager for the GAM memory layer, the next generation of the static per-class connection store (presence bit plus age per node pair). It owns the symmetric edge matrix of every class and executes commands: link a winner/runner-up pair, age all edges of a winner, query an edge, clear a class. Edges whose age exceeds AGE_MAX are pruned automatically. It sits between the memory-layer learning controller (command source) and the node-validity bookkeeping (response sink).

---
 rtl/gam_edge_age_engine.sv | 218 +++++++++++++++++++++
 tb/tb_gam_edge_age_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gam_edge_age_engine.sv
// Per-class symmetric edge/age store for the GAM memory layer: link, age, query, clear.
// Optional GAM_ISOLATION_REPORT_EN adds per-node degree counters that drive rsp_isolated.
module gam_edge_age_engine #(
  parameter int NODE_COUNT  = 10,
  parameter int CLASS_COUNT = 4,
  parameter int AGE_W       = 8,
  parameter int AGE_MAX     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [1:0]                        cmd_op,
  input  logic [$clog2(CLASS_COUNT):0]      cmd_class,
  input  logic [$clog2(NODE_COUNT):0]       cmd_s1,
  input  logic [$clog2(NODE_COUNT):0]       cmd_s2,
  output logic                              rsp_valid,
  output logic                              rsp_err,
  output logic                              rsp_present,
  output logic [AGE_W-1:0]                  rsp_age,
  output logic [$clog2(NODE_COUNT+1)-1:0]   rsp_removed,
  output logic [NODE_COUNT-1:0]             rsp_isolated
);

  localparam int CW  = $clog2(CLASS_COUNT) + 1;
  localparam int NW  = $clog2(NODE_COUNT) + 1;
  localparam int RW  = $clog2(NODE_COUNT + 1);
  localparam int IW  = $clog2(NODE_COUNT);
  localparam int CIW = $clog2(CLASS_COUNT);
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);
  localparam logic [IW-1:0]    K_LAST  = IW'(NODE_COUNT - 1);

  if (AGE_MAX >= (2 ** AGE_W) - 1) begin : g_age_max_check
    $error("AGE_MAX must be below 2^AGE_W-1");
  end

  typedef enum logic [1:0] {IDLE, SWEEP, LINK, RESP} state_t;
  typedef enum logic [1:0] {OP_CONNECT = 2'd0, OP_QUERY = 2'd1, OP_CLEAR = 2'd2, OP_AGE = 2'd3} op_t;

  logic             pres  [CLASS_COUNT][NODE_COUNT][NODE_COUNT];
  logic [AGE_W-1:0] age_m [CLASS_COUNT][NODE_COUNT][NODE_COUNT];

  state_t           state;
  op_t              op;
  logic [CIW-1:0]   c_q, c_n;
  logic [IW-1:0]    a_q, b_q, k, a_n, b_n;
  logic             conn_q;
  logic [RW-1:0]    rem_q, rem_nxt;
  logic             cmd_ok, hit, prune;
  logic [AGE_W-1:0] age_cur, age_inc;
  logic             resp_go, nxt_err, nxt_present;
  logic [AGE_W-1:0] nxt_age;
  logic [RW-1:0]    nxt_removed;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state == IDLE);

  always_comb begin
    c_n    = CIW'(cmd_class - CW'(1));
    a_n    = IW'(cmd_s1 - NW'(1));
    b_n    = IW'(cmd_s2 - NW'(1));
    cmd_ok = (cmd_class != '0) && (cmd_class <= CW'(CLASS_COUNT)) &&
             (cmd_s1 != '0) && (cmd_s1 <= NW'(NODE_COUNT));
    if (op == OP_CONNECT || op == OP_QUERY)
      cmd_ok = cmd_ok && (cmd_s2 != '0) && (cmd_s2 <= NW'(NODE_COUNT)) && (cmd_s2 != cmd_s1);
  end

  // One neighbour k of s1 per sweep cycle; the CONNECT partner is left for LINK.
  always_comb begin
    age_cur = age_m[c_q][a_q][k];
    age_inc = (age_cur == '1) ? age_cur : age_cur + 1'b1;
    hit     = (state == SWEEP) && (k != a_q) && !(conn_q && (k == b_q)) && pres[c_q][a_q][k];
    prune   = hit && (age_inc > AGE_LIM);
    rem_nxt = rem_q + RW'(prune);
  end

  always_comb begin
    resp_go     = 1'b0;
    nxt_err     = 1'b0;
    nxt_present = 1'b0;
    nxt_age     = '0;
    nxt_removed = rem_nxt;
    case (state)
      IDLE: begin
        nxt_removed = '0;
        if (cmd_valid) begin
          if (!cmd_ok) begin
            resp_go = 1'b1;
            nxt_err = 1'b1;
          end else if (op == OP_QUERY) begin
            resp_go     = 1'b1;
            nxt_present = pres[c_n][a_n][b_n];
            nxt_age     = age_m[c_n][a_n][b_n];
          end else if (op == OP_CLEAR) begin
            resp_go = 1'b1;
          end
        end
      end
      SWEEP:   resp_go = (k == K_LAST) && !conn_q;
      LINK:    resp_go = 1'b1;
      default: resp_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      c_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      k           <= '0;
      conn_q      <= 1'b0;
      rem_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_present <= 1'b0;
      rsp_age     <= '0;
      rsp_removed <= '0;
      for (int unsigned c = 0; c < CLASS_COUNT; c++)
        for (int unsigned i = 0; i < NODE_COUNT; i++)
          for (int unsigned j = 0; j < NODE_COUNT; j++) begin
            pres[c][i][j]  <= 1'b0;
            age_m[c][i][j] <= '0;
          end
    end else begin
      rsp_valid <= resp_go;
      if (resp_go) begin
        rsp_err     <= nxt_err;
        rsp_present <= nxt_present;
        rsp_age     <= nxt_age;
        rsp_removed <= nxt_removed;
      end
      case (state)
        IDLE: if (cmd_valid) begin
          c_q    <= c_n;
          a_q    <= a_n;
          b_q    <= b_n;
          conn_q <= (op == OP_CONNECT);
          k      <= '0;
          rem_q  <= '0;
          if (!cmd_ok || op == OP_QUERY) begin
            state <= RESP;
          end else if (op == OP_CLEAR) begin
            state <= RESP;
            for (int unsigned i = 0; i < NODE_COUNT; i++)
              for (int unsigned j = 0; j < NODE_COUNT; j++) begin
                pres[c_n][i][j]  <= 1'b0;
                age_m[c_n][i][j] <= '0;
              end
          end else begin
            state <= SWEEP;
          end
        end
        SWEEP: begin
          if (prune) begin
            pres[c_q][a_q][k]  <= 1'b0;
            pres[c_q][k][a_q]  <= 1'b0;
            age_m[c_q][a_q][k] <= '0;
            age_m[c_q][k][a_q] <= '0;
          end else if (hit) begin
            age_m[c_q][a_q][k] <= age_inc;
            age_m[c_q][k][a_q] <= age_inc;
          end
          rem_q <= rem_nxt;
          k     <= k + 1'b1;
          if (k == K_LAST) state <= conn_q ? LINK : RESP;
        end
        LINK: begin
          pres[c_q][a_q][b_q]  <= 1'b1;
          pres[c_q][b_q][a_q]  <= 1'b1;
          age_m[c_q][a_q][b_q] <= '0;
          age_m[c_q][b_q][a_q] <= '0;
          state                <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GAM_ISOLATION_REPORT_EN
  logic [IW-1:0]         deg [CLASS_COUNT][NODE_COUNT];
  logic [NODE_COUNT-1:0] iso_q, iso_nxt;

  // A node is flagged at the prune that takes its degree to zero, even if LINK later reconnects it.
  always_comb begin
    iso_nxt = iso_q;
    if (prune && deg[c_q][a_q] == IW'(1)) iso_nxt[a_q] = 1'b1;
    if (prune && deg[c_q][k] == IW'(1))   iso_nxt[k]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iso_q        <= '0;
      rsp_isolated <= '0;
      for (int unsigned c = 0; c < CLASS_COUNT; c++)
        for (int unsigned i = 0; i < NODE_COUNT; i++)
          deg[c][i] <= '0;
    end else begin
      iso_q <= (state == IDLE) ? '0 : iso_nxt;
      if (resp_go) rsp_isolated <= (state == IDLE) ? '0 : iso_nxt;
      if (state == IDLE && cmd_valid && cmd_ok && op == OP_CLEAR)
        for (int unsigned i = 0; i < NODE_COUNT; i++)
          deg[c_n][i] <= '0;
      if (prune) begin
        deg[c_q][a_q] <= deg[c_q][a_q] - 1'b1;
        deg[c_q][k]   <= deg[c_q][k] - 1'b1;
      end
      if (state == LINK && !pres[c_q][a_q][b_q]) begin
        deg[c_q][a_q] <= deg[c_q][a_q] + 1'b1;
        deg[c_q][b_q] <= deg[c_q][b_q] + 1'b1;
      end
    end
  end
`else
  assign rsp_isolated = '0;
`endif

endmodule

// File: tb/tb_gam_edge_age_engine.sv
// Scoreboard bench for gam_edge_age_engine: a set-based edge model predicts every response.
module tb_gam_edge_age_engine;

  localparam int NC = 10;
  localparam int CC = 4;
  localparam int AMAX = 2;
  localparam int ASAT = 255;

  logic       clk = 0;
  logic       rst = 1;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_class = '0;
  logic [4:0] cmd_s1 = '0;
  logic [4:0] cmd_s2 = '0;
  logic       rsp_valid, rsp_err, rsp_present;
  logic [7:0] rsp_age;
  logic [3:0] rsp_removed;
  logic [9:0] rsp_isolated;

  gam_edge_age_engine #(.NODE_COUNT(NC), .CLASS_COUNT(CC), .AGE_W(8), .AGE_MAX(AMAX)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_class(cmd_class), .cmd_s1(cmd_s1), .cmd_s2(cmd_s2), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_present(rsp_present), .rsp_age(rsp_age),
    .rsp_removed(rsp_removed), .rsp_isolated(rsp_isolated)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int op; int acc; int lat; bit err; bit present; int age; int removed; int iso;
  } exp_t;
  exp_t q[$];

  int tests = 0;
  int failed = 0;

  bit mp [1:CC][1:NC][1:NC];
  int ma [1:CC][1:NC][1:NC];

  task automatic chk(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int degree(int c, int n);
    int d = 0;
    for (int j = 1; j <= NC; j++) d += mp[c][n][j];
    return d;
  endfunction

  task automatic model_clear_all();
    for (int c = 1; c <= CC; c++)
      for (int i = 1; i <= NC; i++)
        for (int j = 1; j <= NC; j++) begin
          mp[c][i][j] = 0;
          ma[c][i][j] = 0;
        end
  endtask

  task automatic model_run(int op, int c, int s1, int s2, output exp_t e);
    bit ok;
    int nv;
    e = '{default: 0};
    e.op = op;
    e.lat = 1;
    ok = (c >= 1 && c <= CC && s1 >= 1 && s1 <= NC);
    if (op == 0 || op == 1) ok = ok && s2 >= 1 && s2 <= NC && s2 != s1;
    if (!ok) begin
      e.err = 1;
      return;
    end
    case (op)
      1: begin
        e.present = mp[c][s1][s2];
        e.age = ma[c][s1][s2];
      end
      2: for (int i = 1; i <= NC; i++)
           for (int j = 1; j <= NC; j++) begin
             mp[c][i][j] = 0;
             ma[c][i][j] = 0;
           end
      default: begin
        e.lat = (op == 0) ? NC + 2 : NC + 1;
        for (int k = 1; k <= NC; k++) begin
          if (k == s1 || (op == 0 && k == s2) || !mp[c][s1][k]) continue;
          nv = ma[c][s1][k] + 1;
          if (nv > ASAT) nv = ASAT;
          if (nv > AMAX) begin
            mp[c][s1][k] = 0; mp[c][k][s1] = 0;
            ma[c][s1][k] = 0; ma[c][k][s1] = 0;
            e.removed++;
            if (degree(c, k) == 0)  e.iso |= (1 << (k - 1));
            if (degree(c, s1) == 0) e.iso |= (1 << (s1 - 1));
          end else begin
            ma[c][s1][k] = nv; ma[c][k][s1] = nv;
          end
        end
        if (op == 0) begin
          mp[c][s1][s2] = 1; mp[c][s2][s1] = 1;
          ma[c][s1][s2] = 0; ma[c][s2][s1] = 0;
        end
      end
    endcase
`ifndef GAM_ISOLATION_REPORT_EN
    e.iso = 0;
`endif
  endtask

  // track=0 issues a command that will be cut short by reset (no response expected).
  task automatic issue(int op, int c, int s1, int s2, bit track);
    exp_t e;
    int budget;
    @(negedge clk);
    cmd_op = op[1:0];
    cmd_class = c[2:0];
    cmd_s1 = s1[4:0];
    cmd_s2 = s2[4:0];
    cmd_valid = 1;
    budget = 0;
    while (!cmd_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      tests++; failed++;
      $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 0;
    if (!track) return;
    model_run(op, c, s1, s2, e);
    e.acc = cyc;
    q.push_back(e);
    budget = 0;
    @(negedge clk);
    while (!cmd_ready && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      tests++; failed++;
      $display("FAIL done_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      if (q.size() == 0) begin
        tests++; failed++;
        $display("FAIL unexpected_rsp: rsp_valid=1 required 0 (no command outstanding)");
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("rsp_err", rsp_err, e.err);
        if (!e.err) begin
          if (e.op == 1) begin
            chk("rsp_present", rsp_present, e.present);
            chk("rsp_age", rsp_age, e.age);
          end else begin
            chk("rsp_removed", rsp_removed, e.removed);
            chk("rsp_isolated", rsp_isolated, e.iso);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, c, s1, s2;
    model_clear_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rsp_present", rsp_present, 0);
    chk("reset_rsp_age", rsp_age, 0);
    chk("reset_rsp_removed", rsp_removed, 0);
    chk("reset_rsp_isolated", rsp_isolated, 0);

    issue(1, 1, 3, 4, 1);
    issue(0, 1, 3, 4, 1);
    issue(1, 1, 4, 3, 1);
    issue(0, 1, 3, 5, 1);
    issue(3, 1, 3, 0, 1);
    issue(3, 1, 3, 7, 1);
    issue(1, 1, 3, 4, 1);
    issue(1, 1, 3, 5, 1);

    issue(0, 1, 2, 2, 1);
    issue(1, 5, 1, 2, 1);
    issue(1, 0, 1, 2, 1);
    issue(3, 1, 11, 1, 1);
    issue(2, 1, 0, 0, 1);
    issue(1, 1, 3, 5, 1);

    issue(0, 2, 1, 2, 1);
    issue(2, 1, 4, 9, 1);
    issue(1, 1, 3, 5, 1);
    issue(1, 2, 2, 1, 1);

    for (int n = 0; n < 200; n++) begin
      int r = $urandom_range(0, 9);
      op = (r < 3) ? 0 : (r < 6) ? 1 : (r < 7) ? 2 : 3;
      c  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 2);
      s1 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 6);
      s2 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 6);
      issue(op, c, s1, s2, 1);
    end

    issue(0, 1, 3, 4, 1);
    issue(0, 3, 6, 7, 1);
    issue(0, 1, 3, 4, 0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1;
    model_clear_all();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_rsp_valid", rsp_valid, 0);
    chk("post_reset_rsp_removed", rsp_removed, 0);
    issue(1, 1, 3, 4, 1);
    issue(1, 3, 7, 6, 1);
    issue(1, 2, 1, 2, 1);

    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
